multi_channel_timer: RTL

Bus-mapped multi-channel timer peripheral on the 8-bit microprocessor bus, and the successor to the single-channel millisecond timer. A shared prescaler generates a tick strobe. Per tick, NUM_CH independent channels count up to a programmable period. Each channel runs in periodic or one-shot mode and has its own pending flag. All channels share one interrupt line, which has a raise/ack handshake with the processor.

---
 rtl/multi_channel_timer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_channel_timer.sv
// Bus-mapped multi-channel timer: a shared prescaler tick drives NUM_CH up-counters with a per-channel pending flag and one shared IRQ.
// Latency: register reads return data one cycle after the request edge; RAISE follows pending&IE by one cycle.
// Backpressure: none; bus accesses complete in one cycle, and ACK clears the lowest-index pending&IE channel.
module multi_channel_timer #(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         NUM_CH    = 2,
  parameter int         PRESCALE  = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic       BUS_INTERRUPT_ACK,
  output logic       BUS_INTERRUPT_RAISE
);

  localparam int            PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  // prescaler and global tick counter
  logic [PW-1:0]          presc_q, presc_d;
  logic                   tick;
  logic [7:0]             gcnt_q, gcnt_d;

  // per-channel state
  logic [NUM_CH-1:0][7:0] period_q, period_d;
  logic [NUM_CH-1:0][7:0] count_q, count_d;
  logic [NUM_CH-1:0]      en_q, en_d;
  logic [NUM_CH-1:0]      oneshot_q, oneshot_d;
  logic [NUM_CH-1:0]      ie_q, ie_d;
  logic [NUM_CH-1:0]      pend_q, pend_d;
  logic [NUM_CH-1:0]      expire;

  // interrupt and read-back registers
  logic                   raise_q, raise_d;
  logic                   rd_vld_q, rd_vld_d;
  logic [7:0]             rd_dat_q, rd_dat_d;

  // bus decode
  logic                   in_win;
  logic [3:0]             off;
  logic                   wr;
  logic                   rd;
  logic [7:0]             wdat;
  logic [NUM_CH-1:0]      wr_period, wr_ctrl, wr_count, wr_stat;
  logic [NUM_CH-1:0]      ack_clr;

  assign in_win = (BUS_ADDR[7:4] == BASE_ADDR[7:4]);
  assign off    = BUS_ADDR[3:0];
  assign wr     = in_win & BUS_WE;
  assign rd     = in_win & ~BUS_WE;
  assign wdat   = BUS_DATA;
  assign tick   = (presc_q == PRESC_LAST);

  // The bus is only driven in the cycle after a sampled read of our window.
  assign BUS_DATA            = rd_vld_q ? rd_dat_q : 8'hzz;
  assign BUS_INTERRUPT_RAISE = raise_q;

  // Decode channel register writes; channel n lives at offsets 4+4n..7+4n.
  always_comb begin
    wr_period = '0;
    wr_ctrl   = '0;
    wr_count  = '0;
    wr_stat   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (wr && off[3:2] == 2'(n + 1)) begin
        case (off[1:0])
          2'd0:    wr_period[n] = 1'b1;
          2'd1:    wr_ctrl[n]   = 1'b1;
          2'd2:    wr_count[n]  = 1'b1;
          default: wr_stat[n]   = 1'b1;
        endcase
      end
    end
  end

  // ACK targets only the lowest-index channel with pending&IE; scanning downward lets the lowest win.
  always_comb begin
    ack_clr = '0;
    if (BUS_INTERRUPT_ACK) begin
      for (int n = NUM_CH - 1; n >= 0; n--) begin
        if (pend_q[n] && ie_q[n]) begin
          ack_clr    = '0;
          ack_clr[n] = 1'b1;
        end
      end
    end
  end

  // Prescaler wrap and global counter; a GCNT clear overrides a coincident tick.
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    gcnt_d  = gcnt_q;
    if (tick) begin
      gcnt_d = gcnt_q + 8'd1;
    end
    if (wr && off == 4'h1) begin
      gcnt_d = 8'h00;
    end
  end

  // Channel counting; later assignments encode the priorities (COUNT write over tick, CTRL write over one-shot clear, expiry over clears).
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      period_d[n]  = period_q[n];
      count_d[n]   = count_q[n];
      en_d[n]      = en_q[n];
      oneshot_d[n] = oneshot_q[n];
      ie_d[n]      = ie_q[n];
      pend_d[n]    = pend_q[n];
      expire[n]    = 1'b0;

      if (tick && en_q[n] && period_q[n] != 8'd0 && !wr_count[n]) begin
        if (count_q[n] >= period_q[n] - 8'd1) begin
          count_d[n] = 8'd0;
          expire[n]  = 1'b1;
          if (oneshot_q[n]) begin
            en_d[n] = 1'b0;
          end
        end else begin
          count_d[n] = count_q[n] + 8'd1;
        end
      end

      if (wr_period[n]) begin
        period_d[n] = wdat;
      end

      if (wr_ctrl[n]) begin
        en_d[n]      = wdat[0];
        oneshot_d[n] = wdat[1];
        ie_d[n]      = wdat[2];
        if (!en_q[n] && wdat[0]) begin
          count_d[n] = 8'd0;
        end
      end

      if (wr_count[n]) begin
        count_d[n] = 8'd0;
      end

      if (ack_clr[n] || (wr_stat[n] && wdat[0])) begin
        pend_d[n] = 1'b0;
      end
      if (expire[n]) begin
        pend_d[n] = 1'b1;
      end
    end
  end

  // Registered read mux plus the IRQ level, which lags pending&IE by one cycle.
  always_comb begin
    rd_vld_d = rd;
    rd_dat_d = 8'h00;
    raise_d  = |(pend_q & ie_q);
    case (off)
      4'h0:    rd_dat_d = gcnt_q;
      4'h3:    rd_dat_d = {{(8 - NUM_CH){1'b0}}, pend_q};
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (off[3:2] == 2'(n + 1)) begin
            case (off[1:0])
              2'd0:    rd_dat_d = period_q[n];
              2'd1:    rd_dat_d = {5'd0, ie_q[n], oneshot_q[n], en_q[n]};
              2'd2:    rd_dat_d = count_q[n];
              default: rd_dat_d = {7'd0, pend_q[n]};
            endcase
          end
        end
      end
    endcase
  end

  // All state registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q   <= '0;
      gcnt_q    <= 8'h00;
      period_q  <= '0;
      count_q   <= '0;
      en_q      <= '0;
      oneshot_q <= '0;
      ie_q      <= '0;
      pend_q    <= '0;
      raise_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_dat_q  <= 8'h00;
    end else begin
      presc_q   <= presc_d;
      gcnt_q    <= gcnt_d;
      period_q  <= period_d;
      count_q   <= count_d;
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      ie_q      <= ie_d;
      pend_q    <= pend_d;
      raise_q   <= raise_d;
      rd_vld_q  <= rd_vld_d;
      rd_dat_q  <= rd_dat_d;
    end
  end

endmodule
